// File: rtl/iface_announce_seq.sv
// rtl/iface_announce_seq.sv - round-robin multi-channel announce sequencer feeding one FIFO stream
// Optional ANNOUNCE_SEQ_TSTAMP_EN adds out_tstamp (push-time cycle count per entry).
module iface_announce_seq #(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      req_valid,
    input  logic [NCH*DW-1:0]   req_data,
    output logic [NCH-1:0]      req_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [CW-1:0]       out_chan,
    input  logic                out_ready,
    output logic [CNTW-1:0]     count,
    output logic [15:0]         drop_cnt
`ifdef ANNOUNCE_SEQ_TSTAMP_EN
    ,
    output logic [31:0]         out_tstamp
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]  mem_data [DEPTH];
    logic [CW-1:0]  mem_chan [DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]  rr_ptr;
    logic           empty, full, accept_ok, push, pop;
    logic [CW-1:0]  gnt_idx;
    logic [DW-1:0]  gnt_data;
    logic [NCH-1:0] grant;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign accept_ok = !rst && (!full || out_ready);
    assign out_data  = mem_data[rd_ptr[AW-1:0]];
    assign out_chan  = mem_chan[rd_ptr[AW-1:0]];
    assign req_ready = grant;
    assign push      = |grant;

    always_comb begin
        int             k;
        logic [NCH-1:0] vsh;
        logic [NCH*DW-1:0] dsh;
        grant    = '0;
        gnt_idx  = '0;
        gnt_data = '0;
        k        = 0;
        vsh      = '0;
        dsh      = '0;
        for (int i = 0; i < NCH; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NCH) k = k - NCH;
            vsh = req_valid >> k;
            if (accept_ok && (grant == '0) && vsh[0]) begin
                grant    = NCH'(1) << k;
                gnt_idx  = CW'(k);
                dsh      = req_data >> (k * DW);
                gnt_data = dsh[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_chan[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr[AW-1:0]] <= gnt_data;
                mem_chan[wr_ptr[AW-1:0]] <= gnt_idx;
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if ((|req_valid) && !accept_ok && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef ANNOUNCE_SEQ_TSTAMP_EN
    logic [31:0] cyc_cnt;
    logic [31:0] mem_ts [DEPTH];

    assign out_tstamp = mem_ts[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem_ts[i] <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (push) mem_ts[wr_ptr[AW-1:0]] <= cyc_cnt;
        end
    end
`else
    // Timestamp counter and per-entry storage are absent in this build.
`endif

endmodule
